// File: rtl/byte_mem_pkg.sv
// rtl/byte_mem_pkg.sv - shared defaults and response-state encoding for byte_mem_port
package byte_mem_pkg;

  localparam int DEF_MEM_DEPTH      = 1024;
  localparam int DEF_BYTES_PER_WORD = 2;
  localparam int DEF_ADDR_WIDTH     = 16;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/byte_mem_port_if.sv
// rtl/byte_mem_port_if.sv - request/response bus bundle for byte_mem_port
interface byte_mem_port_if
  import byte_mem_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
);

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_wr;
  logic [ADDR_WIDTH-1:0]       req_addr;
  logic [BYTES_PER_WORD-1:0]   req_be;
  logic [8*BYTES_PER_WORD-1:0] req_wdata;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [8*BYTES_PER_WORD-1:0] rsp_rdata;
  logic                        rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/byte_mem_bank.sv
// rtl/byte_mem_bank.sv - byte-wide storage array with one read/write port per lane
module byte_mem_bank #(
  parameter int MEM_DEPTH = 1024,
  parameter int NPORTS    = 2,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                    clock,
  input  logic [NPORTS-1:0]       we,
  input  logic [NPORTS*IDX_W-1:0] idx,
  input  logic [NPORTS*8-1:0]     wdata,
  output logic [NPORTS*8-1:0]     rdata
);

  // Contents are deliberately not reset so data survives a port reset.
  logic [7:0] mem [MEM_DEPTH];

  // Asynchronous read of every lane; the port registers the result at acceptance.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NPORTS; k++) begin
      rdata[k*8 +: 8] = mem[idx[k*IDX_W +: IDX_W]];
    end
  end

  // Per-lane byte writes; lane indices are distinct so no two lanes collide.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NPORTS; k++) begin
      if (we[k]) begin
        mem[idx[k*IDX_W +: IDX_W]] <= wdata[k*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/byte_mem_port.sv
// rtl/byte_mem_port.sv - big-endian byte-addressed memory port, latency 1 (option: BYTE_MEM_ERR_EN)
module byte_mem_port
  import byte_mem_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int MEM_DEPTH      = DEF_MEM_DEPTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
  input  logic            clock,
  input  logic            reset,
  byte_mem_port_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int W     = 8 * BYTES_PER_WORD;

  localparam logic [0:0] ST_EMPTY = RSP_EMPTY;
  localparam logic [0:0] ST_FULL  = RSP_FULL;

  logic [0:0]                      state;
  logic [W-1:0]                    rsp_rdata_q;
  logic                            rsp_err_q;
  logic                            accept;
  logic                            addr_err;
  logic                            do_write;
  logic [BYTES_PER_WORD-1:0]       lane_we;
  logic [BYTES_PER_WORD*IDX_W-1:0] lane_idx;
  logic [W-1:0]                    rd_word;
  logic                            unused_addr;

  assign bus.rsp_valid = (state == ST_FULL);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Reset is folded in so nothing is taken (and no byte written) while reset is low.
  assign bus.req_ready = reset && (!bus.rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // Upper address bits only matter for the range check; fold them here to mark them consumed.
  assign unused_addr = ^bus.req_addr;

`ifdef BYTE_MEM_ERR_EN
  // Out-of-range or misaligned addresses are rejected without touching storage.
  always_comb begin
    addr_err = ({1'b0, bus.req_addr} >= (ADDR_WIDTH+1)'(MEM_DEPTH))
            || ((bus.req_addr & ADDR_WIDTH'(BYTES_PER_WORD-1)) != '0);
  end
`else
  assign addr_err = 1'b0;
`endif

  // Lane k lives at req_addr + (BYTES_PER_WORD-1-k); truncating to IDX_W bits wraps modulo MEM_DEPTH.
  always_comb begin
    lane_idx = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      lane_idx[k*IDX_W +: IDX_W] = bus.req_addr[IDX_W-1:0] + IDX_W'(BYTES_PER_WORD-1-k);
    end
  end

  assign do_write = accept && bus.req_wr && !addr_err;
  assign lane_we  = {BYTES_PER_WORD{do_write}} & bus.req_be;

  byte_mem_bank #(
    .MEM_DEPTH (MEM_DEPTH),
    .NPORTS    (BYTES_PER_WORD),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clock (clock),
    .we    (lane_we),
    .idx   (lane_idx),
    .wdata (bus.req_wdata),
    .rdata (rd_word)
  );

  // Single-entry response register: fill on accept, drain on consume, hold under backpressure.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_EMPTY;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      state       <= ST_FULL;
      rsp_rdata_q <= (bus.req_wr || addr_err) ? '0 : rd_word;
      rsp_err_q   <= addr_err;
    end else if (bus.rsp_ready) begin
      state       <= ST_EMPTY;
    end
  end

endmodule

// File: doc/byte_mem_port.md
BYTE_MEM_PORT -- requirements
Module: byte_mem_port

Interface
REQ-001 Parameter BYTES_PER_WORD, default 2, bytes per access word; SHALL be 1, 2, 4 or 8.
REQ-002 Parameter MEM_DEPTH, default 1024, byte count of storage; SHALL be a power of two.
REQ-003 Parameter ADDR_WIDTH, default 16, request address width in bits.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-008 req_wr  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_WIDTH  byte address of the most significant byte of the word.
REQ-010 req_be  input  BYTES_PER_WORD  byte-lane write enables; bit BYTES_PER_WORD-1 = MSB lane.
REQ-011 req_wdata  input  8*BYTES_PER_WORD  write data, big-endian lanes.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-014 rsp_rdata  output  8*BYTES_PER_WORD  read data, big-endian; 0 for write responses.
REQ-015 rsp_err  output  1  access error flag (MEM_ERR_EN only; tied 0 otherwise).

Function
REQ-016 Byte order: lane k (MSB = lane BYTES_PER_WORD-1) maps to byte address req_addr + (BYTES_PER_WORD-1-k).
REQ-017 Byte addresses SHALL wrap modulo MEM_DEPTH; word straddling MEM_DEPTH-1 continues at byte 0.
REQ-018 Every accepted request (read or write) SHALL produce exactly one response, in order.
REQ-019 Response SHALL appear with rsp_valid=1 on the cycle after acceptance (latency 1).
REQ-020 Single-entry response register; req_ready = !rsp_valid || rsp_ready (combinational).
REQ-021 rsp_valid, rsp_rdata, rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-022 Write: only lanes with req_be bit set are updated at the acceptance edge; req_be=0 is a legal no-op write.
REQ-023 Read SHALL return storage contents sampled at the acceptance edge (read-before-write ordering for same-cycle effects; back-to-back write then read returns new data).
REQ-024 Response-register state: EMPTY -> FULL on acceptance; FULL -> FULL on simultaneous consume+accept; FULL -> EMPTY on consume without accept.
REQ-025 Requests with req_valid=0 SHALL not modify storage or response state.

Reset
REQ-026 reset low SHALL immediately force rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 after reset.
REQ-027 Storage contents SHALL NOT be cleared by reset; a pending response is discarded.
REQ-028 A request presented while reset is low SHALL not be accepted.

Configuration
REQ-029 Macro BYTE_MEM_ERR_EN defined: req_addr >= MEM_DEPTH, or req_addr not a multiple of BYTES_PER_WORD, SHALL yield rsp_err=1, rsp_rdata=0, no storage write.
REQ-030 Macro undefined: no checks; address taken modulo MEM_DEPTH, unaligned accesses legal per REQ-016/017, rsp_err constant 0.

Structure
REQ-031 Package byte_mem_pkg SHALL hold default constants (MEM_DEPTH, BYTES_PER_WORD, ADDR_WIDTH) and the response-state enumeration.
REQ-032 Sub-module byte_mem_bank SHALL implement one 8-bit storage array with byte write enable and wrapped index; byte_mem_port instantiates address/lane mapping around it.

Verification
REQ-033 Reset then write addr 0x0000 data 0x1234 be 2'b11, read addr 0x0000 -> rsp_rdata 0x1234 one cycle after accept.
REQ-034 Write 0xAABB be 2'b10 over 0x1234 at addr 0x0010 -> read returns 0xAA34.
REQ-035 Wrap, BYTE_MEM_ERR_EN off: write 0xCAFE at addr 1023 -> byte 1023 = 0xCA, byte 0 = 0xFE; read addr 1023 returns 0xCAFE.
REQ-036 Backpressure: hold rsp_ready=0 after a read -> req_ready=0, rsp fields stable 3 cycles; assert rsp_ready with new req_valid -> consume and accept same edge.
REQ-037 BYTE_MEM_ERR_EN on: read addr 0x0401 -> rsp_err=1, rsp_rdata=0; write at addr 0x0003 -> rsp_err=1, storage unchanged.
REQ-038 Assert reset low mid-response (rsp_valid=1) -> rsp_valid=0 asynchronously; previously written 0x1234 at 0x0000 still reads back after release.
